// File: rtl/seq_div16x8_pkg.sv
// Shared definitions for the sequential 16/8 restoring divider.
package seq_div16x8_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_div16x8_sub_bk.sv
// N-bit Brent-Kung subtractor: diff = a + ~b + 1, no_borrow = carry out (a >= b).
module div_sub_bk #(
  parameter int unsigned N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         no_borrow
);

  localparam int unsigned L = $clog2(N);
  localparam int unsigned P = 1 << L;

  logic [N-1:0] bn;
  logic [N-1:0] prop;
  logic [P-1:0] gk;
  logic [P-1:0] pk;

  assign bn   = ~b;
  assign prop = a ^ bn;

  // Prefix tree computed in place: up-sweep then down-sweep. The carry-in of 1
  // is folded into bit 0's generate, so gk[i] ends as the carry into bit i+1.
  always_comb begin
    gk = '0;
    pk = '0;
    gk[N-1:0] = a & bn;
    pk[N-1:0] = prop;
    gk[0] = gk[0] | pk[0];
    for (int unsigned k = 1; k <= L; k++) begin
      for (int unsigned i = 0; i < P; i++) begin
        if (((i + 1) % (1 << k)) == 0) begin
          gk[i] = gk[i] | (pk[i] & gk[i - (1 << (k - 1))]);
          pk[i] = pk[i] & pk[i - (1 << (k - 1))];
        end
      end
    end
    for (int unsigned k = L - 1; k >= 1; k--) begin
      for (int unsigned i = 0; i < P; i++) begin
        if ((((i + 1) % (1 << k)) == (1 << (k - 1))) && ((i + 1) > (1 << k))) begin
          gk[i] = gk[i] | (pk[i] & gk[i - (1 << (k - 1))]);
          pk[i] = pk[i] & pk[i - (1 << (k - 1))];
        end
      end
    end
  end

  // Sum bits: carry into bit 0 is 1, into bit i is the prefix generate of i-1.
  always_comb begin
    diff = '0;
    diff[0] = ~prop[0];
    for (int unsigned i = 1; i < N; i++) begin
      diff[i] = prop[i] ^ gk[i - 1];
    end
  end

  assign no_borrow = gk[N-1];

endmodule

// File: rtl/seq_div16x8.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per clock, with divide-by-zero and overflow detection.
module seq_div16x8
  import seq_div16x8_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-2:0] qs;
  logic [WIDTH-1:0] dvr;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   sub_a;
  logic [WIDTH:0]   sub_b;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   r_next;
  logic             no_borrow;
  logic             unused_r_msb;

  assign in_ready = (state == S_IDLE);

  // One subtractor serves both the accept-time overflow compare and the
  // per-iteration trial subtract; IDLE selects the dividend high half.
  always_comb begin
    r_shift = {r, sh[WIDTH-1]};
    if (state == S_IDLE) begin
      sub_a = {1'b0, dividend[2*WIDTH-1:WIDTH]};
      sub_b = {1'b0, divisor};
    end else begin
      sub_a = r_shift;
      sub_b = {1'b0, dvr};
    end
  end

  div_sub_bk #(.N(WIDTH + 1)) u_sub (
    .a         (sub_a),
    .b         (sub_b),
    .diff      (diff),
    .no_borrow (no_borrow)
  );

  // Partial remainder stays below the divisor, so its top bit is always zero
  // and only WIDTH bits are kept between iterations.
  assign r_next       = no_borrow ? diff : r_shift;
  assign unused_r_msb = r_next[WIDTH];

  // Control FSM and datapath registers. On error the results load at accept
  // and out_valid follows one edge later in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      r           <= '0;
      sh          <= '0;
      qs          <= '0;
      dvr         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            dvr         <= divisor;
            cnt         <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            if (divisor == '0) begin
              div_by_zero <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend[WIDTH-1:0];
              state       <= S_DONE;
            end else if (no_borrow) begin
              overflow    <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend[WIDTH-1:0];
              state       <= S_DONE;
            end else begin
              r     <= dividend[2*WIDTH-1:WIDTH];
              sh    <= dividend[WIDTH-1:0];
              qs    <= '0;
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r   <= r_next[WIDTH-1:0];
          sh  <= {sh[WIDTH-2:0], 1'b0};
          qs  <= {qs[WIDTH-3:0], no_borrow};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            quotient  <= {qs, no_borrow};
            remainder <= r_next[WIDTH-1:0];
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div16x8.sv
// Directed and random checks of seq_div16x8 with an expected-result queue.
module tb_seq_div16x8;

  typedef struct {
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dz;
    logic        ov;
    int unsigned lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  logic        overflow;

  int unsigned total = 0;
  int unsigned bad   = 0;
  exp_t        sb[$];

  seq_div16x8 #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] q, input logic [7:0] r,
                              input logic dz, input logic ov);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz; e.ov = ov;
    e.lat = (dz || ov) ? 1 : 8;
    return e;
  endfunction

  // Drive one operation, scramble the inputs right after accept, wait for the
  // result, compare it with the queued expectation, optionally stall, then drain.
  task automatic run_op(input logic [15:0] dd, input logic [7:0] dv,
                        input exp_t e, input int unsigned hold);
    exp_t        got;
    int unsigned n;
    logic [7:0]  cq, cr;
    sb.push_back(e);
    @(negedge clk);
    dividend  = dd;
    divisor   = dv;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    chk("busy_after_accept", {31'd0, in_ready}, 32'd0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    got = sb.pop_front();
    chk("latency", n, got.lat);
    chk("quotient", {24'd0, quotient}, {24'd0, got.q});
    chk("remainder", {24'd0, remainder}, {24'd0, got.r});
    chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, got.dz});
    chk("overflow", {31'd0, overflow}, {31'd0, got.ov});
    cq = quotient;
    cr = remainder;
    for (int unsigned i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_quotient", {24'd0, quotient}, {24'd0, cq});
      chk("hold_remainder", {24'd0, remainder}, {24'd0, cr});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    int unsigned a, b, r;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_quotient", {24'd0, quotient}, 32'd0);
    chk("rst_remainder", {24'd0, remainder}, 32'd0);
    chk("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h7530, 8'd150, mk(8'd200, 8'd0, 1'b0, 1'b0), 0);
    run_op(16'h7541, 8'd150, mk(8'd200, 8'd17, 1'b0, 1'b0), 0);
    run_op(16'h00FF, 8'd1, mk(8'd255, 8'd0, 1'b0, 1'b0), 0);
    run_op(16'h0000, 8'd7, mk(8'd0, 8'd0, 1'b0, 1'b0), 0);
    run_op(16'h1234, 8'd0, mk(8'hFF, 8'h34, 1'b1, 1'b0), 0);
    run_op(16'h9600, 8'd150, mk(8'hFF, 8'h00, 1'b0, 1'b1), 0);
    run_op(16'h95FF, 8'd150, mk(8'd255, 8'd149, 1'b0, 1'b0), 0);
    run_op(16'h0000, 8'd0, mk(8'hFF, 8'h00, 1'b1, 1'b0), 2);
    run_op(16'h7541, 8'd150, mk(8'd200, 8'd17, 1'b0, 1'b0), 5);

    // Reset in the middle of RUN: outputs clear asynchronously, nothing emitted.
    @(negedge clk);
    dividend = 16'h7541;
    divisor  = 8'd150;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_quotient", {24'd0, quotient}, 32'd0);
    chk("async_rst_remainder", {24'd0, remainder}, 32'd0);
    chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
    end

    run_op(16'h7530, 8'd150, mk(8'd200, 8'd0, 1'b0, 1'b0), 0);

    for (int unsigned k = 0; k < 3000; k++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(1, 255);
      r = $urandom_range(0, b - 1);
      run_op(16'(a * b + r), 8'(b), mk(8'(a), 8'(r), 1'b0, 1'b0), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
